riscv_mc: RTL
=============

# riscv_mc

Multicycle RV32I core, the parametrised successor to the single-cycle core. It executes one instruction per 3–5 cycles through a state machine. Instruction and data traffic share one memory port with a req/ready handshake, so the core tolerates wait states. Register count and reset vector are parameters. The register file is exposed for debug, and the core halts on illegal or trapping instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NREGS`, default 32: architectural register count, 32 (RV32I) or 16 (RV32E).
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, asynchronous, active-low.
- `memReq` output 1: memory transfer request.
- `memWe` output 1: transfer is a write (valid only while `memReq`=1).
- `memAdr` output 32: byte address, word-aligned.
- `memWData` output 32: write data.
- `memRData` input 32: read data, sampled on the completing edge.
- `memReady` input 1: memory accepts or completes the transfer this cycle.
- `PC` output 32: address of the current instruction.
- `halt` output 1: core stopped.
- `regs` output [NREGS-1:0][31:0]: register file contents, debug view.

## Operation
- States: START, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters START; START always goes to FETCH on the next edge.
- FETCH: `memReq`=1, `memWe`=0, `memAdr`=PC. Wait while `memReady`=0. On a completing edge, latch IR from `memRData` and go to DECODE.
- DECODE: read rs1 and rs2, build the immediate, compute the branch/jal target PC+imm. Illegal instructions go to HALT.
- EXEC:
  - ALU ops, lui, auipc, jal, jalr: compute the result, then go to WB.
  - lw/sw: compute the address. A misaligned address (`addr[1:0]`≠0) goes to HALT; otherwise go to MEM.
  - Branches: evaluate the condition, set PC to the target or PC+4, then go to FETCH.
- MEM: `memReq`=1, `memAdr`=address, `memWe`=1 for sw with `memWData`=rs2. Wait for `memReady`. After completion, lw goes to WB and sw goes to FETCH with PC+4.
- WB:
  - Write rd when rd≠0.
  - Next PC: PC+4 in general; jal uses the target; jalr uses `(rs1+imm)&~1`.
  - jal/jalr write rd=PC+4.
  - Then go to FETCH.
- Supported instructions:
  - lui, auipc, jal, jalr.
  - beq, bne, blt, bge, bltu, bgeu.
  - lw, sw.
  - addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - add, sub, sll, slt, sltu, xor, srl, sra, or, and.
- Illegal (go to HALT with `halt`=1): any other opcode/funct combination, ecall/ebreak, and any rd/rs1/rs2 index ≥ NREGS.
- HALT is sticky until reset. `memReq`=0; PC holds the faulting instruction's address.
- Register x0 reads 0 and ignores writes. All arithmetic is mod 2^32. Shift amount is the low 5 bits. slt is signed; sltu is unsigned.

## Timing
- Reset values (asynchronous): PC=RESET_PC, all regs=0, IR=0, `halt`=0, `memReq`=0, `memWe`=0, `memAdr`=0, `memWData`=0.
- Memory outputs are registered. They are stable from the first request cycle until the completing edge, which is any rising edge with `memReq`&`memReady`=1.
- `memReady` while `memReq`=0 is ignored. `memAdr`/`memWData` are 0 outside FETCH and MEM.
- First fetch request: cycle 2 after `rst` deasserts (cycle 1 is START).
- Cycles per instruction with zero-wait memory: branch 3, ALU/lui/auipc/jal/jalr/sw 4, lw 5. Each wait cycle adds 1.
- PC updates on the edge leaving EXEC (branches), MEM (sw) or WB (all others). `regs` updates on the edge leaving WB.
- Reset asserted mid-transaction drops `memReq` immediately; no partial state is retained.

## Configuration
- `RISCV_MC_MUL_EN` defined: R-type funct7=0000001 with funct3=000 (mul) is legal. rd gets the low 32 bits of rs1×rs2; EXEC takes 1 cycle (single-cycle multiplier). All other M-extension encodings remain illegal.
- `RISCV_MC_MUL_EN` undefined: mul is illegal and goes to HALT. No multiplier is synthesised.

## Test plan
- Reset with RESET_PC=32'h100, `memReady` tied 1: first `memReq` in cycle 2 with `memAdr`=0x100. All regs=0, `halt`=0.
- Program `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sw x3,8(x0); lw x4,8(x0)` with zero-wait memory: x3=2, write of 2 to address 8 seen, x4=2. Total 21 cycles after the first fetch edge.
- Same program with `memReady` low for 3 cycles on every request: identical results, and outputs stay stable while waiting.
- `bne x1,x2,-8` taken and not taken, plus `jal x1,16` at PC=0x20: PC follows target/PC+4; x1=0x24 and PC=0x30.
- `lw x5,2(x0)`, opcode 0x00000000, and `addi x20,x0,1` with NREGS=16: each sets `halt`=1 with PC held and no further `memReq`. Deasserting `rst` recovers.
- With `RISCV_MC_MUL_EN`, `mul x3,x1,x2` with x1=0x10000, x2=0x10001: x3=0x00010000. Without it, the same instruction halts.

Source files
------------

// File: rtl/riscv_mc.sv
// riscv_mc: multicycle RV32I/RV32E core with one shared req/ready memory port.
// Optional feature macro: RISCV_MC_MUL_EN enables the single-cycle mul instruction.
module riscv_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREGS    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   memReq,
  output logic                   memWe,
  output logic [31:0]            memAdr,
  output logic [31:0]            memWData,
  input  logic [31:0]            memRData,
  input  logic                   memReady,
  output logic [31:0]            PC,
  output logic                   halt,
  output logic [NREGS-1:0][31:0] regs
);

  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state, state_next;
  logic [31:0] ir, a, b, imm, tgt, res;
  logic [31:0] pc_next, pc_plus4, eff_adr, imm_c;
  logic [31:0] op_b, alu, sra_res, exec_res;
  logic [4:0]  shamt;
  logic        alt, br_base, br_take, legal;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_imm, is_op;
  logic       uses_rd, uses_rs1, uses_rs2;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  assign is_lui   = (opcode == OPC_LUI);
  assign is_auipc = (opcode == OPC_AUIPC);
  assign is_jal   = (opcode == OPC_JAL);
  assign is_jalr  = (opcode == OPC_JALR);
  assign is_br    = (opcode == OPC_BR);
  assign is_ld    = (opcode == OPC_LD);
  assign is_st    = (opcode == OPC_ST);
  assign is_imm   = (opcode == OPC_IMM);
  assign is_op    = (opcode == OPC_OP);

  assign uses_rd  = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_imm | is_op;
  assign uses_rs1 = is_jalr | is_br | is_ld | is_st | is_imm | is_op;
  assign uses_rs2 = is_br | is_st | is_op;

  assign pc_plus4 = PC + 32'd4;
  assign eff_adr  = a + imm;

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  // Immediate generation per instruction format
  always_comb begin
    imm_c = {{20{ir[31]}}, ir[31:20]};
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm_c = {ir[31:12], 12'b0};
      OPC_JAL:            imm_c = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OPC_BR:             imm_c = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_ST:             imm_c = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      default:            ;
    endcase
  end

  // Legality: supported encodings and register indices inside the file
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
      OPC_JALR:      legal = (f3 == 3'b000);
      OPC_BR:        legal = (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LD, OPC_ST: legal = (f3 == 3'b010);
      OPC_IMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      OPC_OP: legal = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      default: legal = 1'b0;
    endcase
`ifdef RISCV_MC_MUL_EN
    if (is_op && (f7 == 7'b0000001) && (f3 == 3'b000)) legal = 1'b1;
`endif
    if (uses_rd  && !idx_ok(rd))  legal = 1'b0;
    if (uses_rs1 && !idx_ok(rs1)) legal = 1'b0;
    if (uses_rs2 && !idx_ok(rs2)) legal = 1'b0;
  end

  // ALU, branch compare and EXEC result select
  always_comb begin
    op_b    = is_op ? b : imm;
    shamt   = op_b[4:0];
    alt     = ir[30] & (is_op | (f3 == 3'b101));
    sra_res = $signed(a) >>> shamt;
    case (f3)
      3'b000:  alu = alt ? (a - op_b) : (a + op_b);
      3'b001:  alu = a << shamt;
      3'b010:  alu = {31'b0, $signed(a) < $signed(op_b)};
      3'b011:  alu = {31'b0, a < op_b};
      3'b100:  alu = a ^ op_b;
      3'b101:  alu = alt ? sra_res : (a >> shamt);
      3'b110:  alu = a | op_b;
      default: alu = a & op_b;
    endcase
    exec_res = alu;
    if (is_lui)                exec_res = imm;
    else if (is_auipc)         exec_res = tgt;
    else if (is_jal | is_jalr) exec_res = pc_plus4;
`ifdef RISCV_MC_MUL_EN
    if (is_op && (f7 == 7'b0000001)) exec_res = a * b;
`endif
    case (f3[2:1])
      2'b00:   br_base = (a == b);
      2'b10:   br_base = ($signed(a) < $signed(b));
      default: br_base = (a < b);
    endcase
    br_take = br_base ^ f3[0];
  end

  // Next-state and next-PC
  always_comb begin
    state_next = state;
    pc_next    = PC;
    case (state)
      S_START:  state_next = S_FETCH;
      S_FETCH:  if (memReady) state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_br) begin
          state_next = S_FETCH;
          pc_next    = br_take ? tgt : pc_plus4;
        end else if (is_ld || is_st) begin
          state_next = (eff_adr[1:0] != 2'b00) ? S_HALT : S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (memReady) begin
          if (is_st) begin
            state_next = S_FETCH;
            pc_next    = pc_plus4;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        pc_next    = (is_jal || is_jalr) ? tgt : pc_plus4;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_START;
    else      state <= state_next;
  end

  // Datapath registers and registered memory-port outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      imm      <= '0;
      tgt      <= '0;
      res      <= '0;
      regs     <= '0;
      halt     <= 1'b0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAdr   <= '0;
      memWData <= '0;
    end else begin
      PC       <= pc_next;
      halt     <= (state_next == S_HALT);
      memReq   <= (state_next == S_FETCH) || (state_next == S_MEM);
      memWe    <= (state_next == S_MEM) && is_st;
      memAdr   <= (state_next == S_FETCH) ? pc_next :
                  (state_next == S_MEM)   ? eff_adr : '0;
      memWData <= ((state_next == S_MEM) && is_st) ? b : '0;
      case (state)
        S_FETCH: if (memReady) ir <= memRData;
        S_DECODE: begin
          a   <= regs[rs1[IDX_W-1:0]];
          b   <= regs[rs2[IDX_W-1:0]];
          imm <= imm_c;
          tgt <= PC + imm_c;
        end
        S_EXEC: begin
          res <= exec_res;
          if (is_jalr) tgt <= {eff_adr[31:1], 1'b0};
        end
        S_MEM: if (memReady && !is_st) res <= memRData;
        S_WB:  if (rd != 5'd0) regs[rd[IDX_W-1:0]] <= res;
        default: ;
      endcase
    end
  end

endmodule
